// File: rtl/convn_valid_sdiv_20s_10s_seq.sv
// convn_valid_sdiv_20s_10s_seq
// Sequential signed divider for the convn_valid datapath. It takes the
// magnitudes of the operands, runs one restoring radix-2 step per cycle and
// applies the sign fix-up on the edge that finishes the last bit.
// Results are offered through a valid/ready handshake.
module convn_valid_sdiv_20s_10s_seq #(
    parameter int DIVIDEND_W = 20,
    parameter int DIVISOR_W  = 10
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam int PW    = DIVISOR_W + 1;
    localparam int SW    = DIVISOR_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [PW-1:0]         prem_q, prem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  zero_q, zero_d;
    logic [DIVISOR_W-1:0]  low_q, low_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [DIVIDEND_W-1:0] dividend_abs;
    logic [DIVISOR_W-1:0]  divisor_abs;
    logic [SW-1:0]         shifted;
    logic [SW-1:0]         trial;
    logic                  take;
    logic [PW-1:0]         prem_step;
    logic [DIVIDEND_W-1:0] quo_mag;
    logic [DIVISOR_W-1:0]  rem_mag;

    // Operand magnitudes; the most negative value maps onto its exact unsigned magnitude
    always_comb begin
        dividend_abs = dividend[DIVIDEND_W-1] ? (~dividend + DIVIDEND_W'(1)) : dividend;
        divisor_abs  = divisor[DIVISOR_W-1]   ? (~divisor + DIVISOR_W'(1))   : divisor;
    end

    // One restoring step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        shifted   = {prem_q, dvd_q[DIVIDEND_W-1]};
        take      = (shifted >= {2'b00, dsr_q});
        trial     = shifted - {2'b00, dsr_q};
        prem_step = PW'(take ? trial : shifted);
        quo_mag   = {dvd_q[DIVIDEND_W-2:0], take};
        rem_mag   = prem_step[DIVISOR_W-1:0];
    end

    // Next-state and datapath control for the IDLE/CALC/DONE sequence
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        low_d     = low_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d     = dividend_abs;
                    dsr_d     = divisor_abs;
                    prem_d    = '0;
                    cnt_d     = CNT_W'(DIVIDEND_W - 1);
                    neg_quo_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    neg_rem_d = dividend[DIVIDEND_W-1];
                    zero_d    = (divisor == '0);
                    low_d     = dividend[DIVISOR_W-1:0];
                    state_d   = CALC;
                end
            end
            CALC: begin
                dvd_d  = quo_mag;
                prem_d = prem_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (zero_q) begin
                        quo_d = '1;
                        rem_d = low_q;
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = neg_quo_q ? (~quo_mag + DIVIDEND_W'(1)) : quo_mag;
                        rem_d = neg_rem_q ? (~rem_mag + DIVISOR_W'(1))  : rem_mag;
                        dbz_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and registered handshake outputs with asynchronous clear
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            low_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            low_q       <= low_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_convn_valid_sdiv_20s_10s_seq.sv
// Testbench for convn_valid_sdiv_20s_10s_seq.
// A cycle-level reference model predicts when results appear and what they
// are, using plain integer division; a compare process checks every cycle.
module tb_convn_valid_sdiv_20s_10s_seq;

    localparam int DW = 20;
    localparam int SW = 10;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit            busy    = 1'b0;
    bit            m_valid = 1'b0;
    int            left    = 0;
    int            cycle   = 0;
    logic [DW-1:0] m_q     = '0;
    logic [SW-1:0] m_r     = '0;
    logic          m_z     = 1'b0;

    convn_valid_sdiv_20s_10s_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Hard stop in case the bench itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Signed division as the arithmetic defines it: truncate toward zero,
    // remainder takes the dividend sign, zero divisor gives the fixed pattern
    function automatic void model(input logic [DW-1:0] a, input logic [SW-1:0] b,
                                  output logic [DW-1:0] q, output logic [SW-1:0] r,
                                  output logic z);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '1;
            r = a[SW-1:0];
            z = 1'b1;
        end else begin
            q = DW'(sa / sb);
            r = SW'(sa % sb);
            z = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // Transaction-level timing model: accept, 20 busy edges, hold until taken
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            busy    = 1'b0;
            m_valid = 1'b0;
            left    = 0;
        end else begin
            cycle++;
            if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    busy    = 1'b0;
                end
            end else if (busy) begin
                left--;
                if (left == 0) m_valid = 1'b1;
            end else if (in_valid) begin
                busy = 1'b1;
                left = DW;
                model(dividend, divisor, m_q, m_r, m_z);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
            checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
            checkOutput("rst_quotient", 32'(quotient), 32'(0));
            checkOutput("rst_remainder", 32'(remainder), 32'(0));
            checkOutput("rst_div_by_zero", 32'(div_by_zero), 32'(0));
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("in_ready", 32'(in_ready), 32'(!busy));
            if (m_valid) begin
                checkOutput("quotient", 32'(quotient), 32'(m_q));
                checkOutput("remainder", 32'(remainder), 32'(m_r));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(m_z));
            end
        end
    end

    // Present one operand pair for a single accept edge
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [SW-1:0] b);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge ap_clk);
            n++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'(1));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
    endtask

    // Wait for the result and confirm it lands exactly DW edges after accept
    task automatic waitResult();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        checkOutput("latency", 32'(n), 32'(DW));
    endtask

    // One full operation with literal expectations and optional backpressure
    task automatic runOp(input int a, input int b, input int lq, input int lr,
                         input int lz, input int hold);
        logic [DW-1:0] eq;
        logic [SW-1:0] er;
        eq = DW'(lq);
        er = SW'(lr);
        applyStimulus(DW'(a), SW'(b));
        waitResult();
        checkOutput("lit_quotient", 32'(quotient), 32'(eq));
        checkOutput("lit_remainder", 32'(remainder), 32'(er));
        checkOutput("lit_div_by_zero", 32'(div_by_zero), 32'(lz));
        checkOutput("pin_model_q", 32'(m_q), 32'(eq));
        checkOutput("pin_model_r", 32'(m_r), 32'(er));
        repeat (hold) @(negedge ap_clk);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int t1;
        int t2;
        int n;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge ap_clk);
        #1 ap_rst_n = 1'b1;

        $display("[TB] basic division and sign combinations");
        runOp(100, 7, 14, 2, 0, 0);
        runOp(-100, 7, -14, -2, 0, 0);
        runOp(100, -7, -14, 2, 0, 0);
        runOp(-100, -7, 14, -2, 0, 0);
        runOp(5, 9, 0, 5, 0, 0);
        runOp(-524288, 1, -524288, 0, 0, 0);
        runOp(1000, -512, -1, 488, 0, 0);

        $display("[TB] overflow wrap and divide by zero");
        runOp(-524288, -1, -524288, 0, 0, 0);
        runOp(37, 0, -1, 37, 1, 0);
        runOp(-37, 0, -1, -37, 1, 0);

        $display("[TB] backpressure");
        runOp(40, 8, 5, 0, 0, 5);
        runOp(-1, 0, -1, -1, 1, 2);

        $display("[TB] reset during calculation");
        applyStimulus(DW'(12345), SW'(11));
        repeat (9) @(negedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        checkOutput("async_quotient", 32'(quotient), 32'(0));
        checkOutput("async_remainder", 32'(remainder), 32'(0));
        checkOutput("async_div_by_zero", 32'(div_by_zero), 32'(0));
        checkOutput("async_out_valid", 32'(out_valid), 32'(0));
        checkOutput("async_in_ready", 32'(in_ready), 32'(1));
        @(negedge ap_clk);
        #1 ap_rst_n = 1'b1;
        runOp(1000, -3, -333, 1, 0, 0);

        $display("[TB] back-to-back throughput");
        dividend  = DW'(1000);
        divisor   = SW'(7);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge ap_clk);
            n++;
        end
        t1 = cycle;
        n = 0;
        while (out_valid && n < 10) begin
            @(negedge ap_clk);
            n++;
        end
        n = 0;
        while (!out_valid && n < 60) begin
            @(negedge ap_clk);
            n++;
        end
        t2 = cycle;
        checkOutput("throughput", 32'(t2 - t1), 32'(DW + 2));
        in_valid = 1'b0;
        @(negedge ap_clk);
        out_ready = 1'b0;
        repeat (3) @(negedge ap_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
